// File: rtl/bats_feed_arbiter.sv
// Packet-granular round-robin arbiter sharing one BATS parser UDP input between
// several multicast feeds; also sequences the parser code-reset pulse.
module bats_feed_arbiter #(
  parameter int NUM_FEEDS  = 2,
  parameter int GAP_CYCLES = 1,
  parameter int INIT_WAIT  = 5,
  parameter int MAX_WORDS  = 192
) (
  input  logic                    Clk40,
  input  logic                    reset,
  input  logic [NUM_FEEDS-1:0]    feed_valid,
  input  logic [64*NUM_FEEDS-1:0] feed_bytes,
  input  logic [8*NUM_FEEDS-1:0]  feed_byte_enables,
  input  logic [NUM_FEEDS-1:0]    feed_last,
  output logic [NUM_FEEDS-1:0]    feed_ready,
  input  logic                    ip_ready,
  output logic [63:0]             ip_bytes,
  output logic [7:0]              ip_byte_enables,
  output logic                    ip_data_valid,
  output logic                    ip_reset,
  output logic [2:0]              grant_id,
  output logic                    busy,
  output logic                    overflow_err,
  output logic                    be_err,
  output logic [2:0]              state_dbg
);

  typedef enum logic [2:0] {
    S_INIT_RST  = 3'd0,
    S_INIT_WAIT = 3'd1,
    S_IDLE      = 3'd2,
    S_STREAM    = 3'd3,
    S_ABORT     = 3'd4,
    S_DRAIN     = 3'd5,
    S_GAP       = 3'd6
  } state_t;

  localparam int WC_W     = $clog2(MAX_WORDS) + 1;
  localparam int CNT_MAX  = (INIT_WAIT > GAP_CYCLES) ? INIT_WAIT : GAP_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam state_t AFTER_PKT = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

  state_t            state_q, state_d;
  logic [2:0]        grant_q, grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic [63:0]       ip_bytes_q, ip_bytes_d;
  logic [7:0]        ip_be_q, ip_be_d;
  logic              ip_dv_q, ip_dv_d;
  logic              ip_reset_q, ip_reset_d;
  logic              ovf_q, ovf_d;
  logic              be_err_q, be_err_d;

  logic              sel_valid;
  logic              sel_last;
  logic [63:0]       sel_bytes;
  logic [7:0]        sel_be;
  logic              arb_found;
  logic [2:0]        arb_pick;

  // Handshake: a feed word moves when feed_valid[i] and feed_ready[i] are both
  // high at a rising Clk40 edge; feed_ready depends only on registered state
  // and ip_ready, never on feed_valid, so there is no combinational loop.

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_bytes = '0;
    sel_be    = '0;
    for (int i = 0; i < NUM_FEEDS; i++) begin
      if (grant_q == 3'(i)) begin
        sel_valid = feed_valid[i];
        sel_last  = feed_last[i];
        sel_bytes = feed_bytes[i*64 +: 64];
        sel_be    = feed_byte_enables[i*8 +: 8];
      end
    end
  end

  // Search starts one past the last owner, so the feed that just finished ranks lowest.
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = grant_q;
    for (int k = 1; k <= NUM_FEEDS; k++) begin
      if (!arb_found && feed_valid[(int'(grant_q) + k) % NUM_FEEDS]) begin
        arb_found = 1'b1;
        arb_pick  = 3'((int'(grant_q) + k) % NUM_FEEDS);
      end
    end
  end

  always_comb begin
    feed_ready = '0;
    for (int i = 0; i < NUM_FEEDS; i++) begin
      if (grant_q == 3'(i)) begin
        feed_ready[i] = ((state_q == S_STREAM) && ip_ready) || (state_q == S_DRAIN);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    word_cnt_d = word_cnt_q;
    ip_bytes_d = '0;
    ip_be_d    = '0;
    ip_dv_d    = 1'b0;
    ip_reset_d = 1'b0;
    ovf_d      = ovf_q;
    be_err_d   = be_err_q;
    case (state_q)
      S_INIT_RST: begin
        ip_reset_d = 1'b1;
        cnt_d      = '0;
        state_d    = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        if (cnt_q == CNT_W'(INIT_WAIT - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_IDLE: begin
        word_cnt_d = '0;
        if (arb_found) begin
          grant_d = arb_pick;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (sel_valid && ip_ready) begin
          word_cnt_d = word_cnt_q + WC_W'(1);
          if (sel_last) begin
            ip_bytes_d = sel_bytes;
            ip_be_d    = sel_be;
            ip_dv_d    = 1'b1;
            cnt_d      = '0;
            state_d    = AFTER_PKT;
          end else if (word_cnt_q == WC_W'(MAX_WORDS - 1)) begin
            // Overflowing word is swallowed; the parser gets a code reset instead.
            state_d = S_ABORT;
          end else begin
            ip_bytes_d = sel_bytes;
            ip_be_d    = sel_be;
            ip_dv_d    = 1'b1;
            if (sel_be != 8'hFF) be_err_d = 1'b1;
          end
        end
      end
      S_ABORT: begin
        ip_reset_d = 1'b1;
        ovf_d      = 1'b1;
        state_d    = S_DRAIN;
      end
      S_DRAIN: begin
        if (sel_valid && sel_last) begin
          cnt_d   = '0;
          state_d = AFTER_PKT;
        end
      end
      S_GAP: begin
        word_cnt_d = '0;
        if (cnt_q == CNT_W'(GAP_LAST)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_INIT_RST;
    endcase
  end

  always_ff @(posedge Clk40 or posedge reset) begin
    if (reset) begin
      state_q    <= S_INIT_RST;
      grant_q    <= '0;
      cnt_q      <= '0;
      word_cnt_q <= '0;
      ip_bytes_q <= '0;
      ip_be_q    <= '0;
      ip_dv_q    <= 1'b0;
      ip_reset_q <= 1'b0;
      ovf_q      <= 1'b0;
      be_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      word_cnt_q <= word_cnt_d;
      ip_bytes_q <= ip_bytes_d;
      ip_be_q    <= ip_be_d;
      ip_dv_q    <= ip_dv_d;
      ip_reset_q <= ip_reset_d;
      ovf_q      <= ovf_d;
      be_err_q   <= be_err_d;
    end
  end

  assign ip_bytes        = ip_bytes_q;
  assign ip_byte_enables = ip_be_q;
  assign ip_data_valid   = ip_dv_q;
  assign ip_reset        = ip_reset_q;
  assign grant_id        = grant_q;
  assign busy            = (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign overflow_err    = ovf_q;
  assign be_err          = be_err_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_bats_feed_arbiter.sv
// Directed bench for bats_feed_arbiter: feed queues drive the inputs, an
// expected queue of {grant, enables, word} checks everything on the parser side.
module tb_bats_feed_arbiter;

  localparam int NF = 2;
  localparam int MW = 192;

  logic              clk;
  logic              reset;
  logic [NF-1:0]     feed_valid;
  logic [64*NF-1:0]  feed_bytes;
  logic [8*NF-1:0]   feed_byte_enables;
  logic [NF-1:0]     feed_last;
  logic [NF-1:0]     feed_ready;
  logic              ip_ready;
  logic [63:0]       ip_bytes;
  logic [7:0]        ip_byte_enables;
  logic              ip_data_valid;
  logic              ip_reset;
  logic [2:0]        grant_id;
  logic              busy;
  logic              overflow_err;
  logic              be_err;
  logic [2:0]        state_dbg;

  int checks = 0;
  int errors = 0;
  int rst_cnt = 0;

  logic [72:0] fq0[$];
  logic [72:0] fq1[$];
  logic [74:0] exp_q[$];

  bats_feed_arbiter #(
    .NUM_FEEDS(NF), .GAP_CYCLES(1), .INIT_WAIT(5), .MAX_WORDS(MW)
  ) dut (
    .Clk40(clk), .reset(reset),
    .feed_valid(feed_valid), .feed_bytes(feed_bytes),
    .feed_byte_enables(feed_byte_enables), .feed_last(feed_last),
    .feed_ready(feed_ready), .ip_ready(ip_ready),
    .ip_bytes(ip_bytes), .ip_byte_enables(ip_byte_enables),
    .ip_data_valid(ip_data_valid), .ip_reset(ip_reset),
    .grant_id(grant_id), .busy(busy), .overflow_err(overflow_err),
    .be_err(be_err), .state_dbg(state_dbg)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive_feeds();
    feed_valid = '0;
    feed_bytes = '0;
    feed_byte_enables = '0;
    feed_last = '0;
    if (fq0.size() != 0) begin
      feed_valid[0]            = 1'b1;
      feed_last[0]             = fq0[0][72];
      feed_byte_enables[7:0]   = fq0[0][71:64];
      feed_bytes[63:0]         = fq0[0][63:0];
    end
    if (fq1.size() != 0) begin
      feed_valid[1]            = 1'b1;
      feed_last[1]             = fq1[0][72];
      feed_byte_enables[15:8]  = fq1[0][71:64];
      feed_bytes[127:64]       = fq1[0][63:0];
    end
  endtask

  task automatic push_word(input int f, input logic last, input logic [7:0] be,
                           input logic [63:0] w, input bit fwd);
    if (f == 0) fq0.push_back({last, be, w});
    else        fq1.push_back({last, be, w});
    if (fwd) exp_q.push_back({3'(f), be, w});
  endtask

  task automatic monitor();
    if (ip_reset) rst_cnt++;
    if (ip_data_valid) begin
      if (exp_q.size() == 0) chk("ip_unexpected_valid", 80'(ip_data_valid), 80'd0);
      else chk("ip_word", {5'd0, grant_id, ip_byte_enables, ip_bytes}, 80'(exp_q.pop_front()));
    end else begin
      chk("ip_idle_zero", {8'd0, ip_byte_enables, ip_bytes}, 80'd0);
    end
  endtask

  // One clock: transfers are decided from the inputs seen just before the edge.
  task automatic tick();
    logic [NF-1:0] acc;
    @(negedge clk);
    acc = feed_valid & feed_ready;
    @(posedge clk);
    #1;
    if (acc[0] && fq0.size() != 0) void'(fq0.pop_front());
    if (acc[1] && fq1.size() != 0) void'(fq1.pop_front());
    drive_feeds();
    monitor();
  endtask

  task automatic run_until_empty(input string tag, input int budget);
    for (int i = 0; i < budget && (exp_q.size() != 0 || fq0.size() != 0 || fq1.size() != 0); i++)
      tick();
    chk(tag, 80'(exp_q.size() + fq0.size() + fq1.size()), 80'd0);
  endtask

  initial begin
    reset = 1'b1;
    ip_ready = 1'b1;
    drive_feeds();
    #1;
    chk("rst_state", {69'd0, ip_data_valid, ip_reset, feed_ready, grant_id, busy, overflow_err, be_err}, 80'd0);
    chk("rst_ip_bytes", {8'd0, ip_byte_enables, ip_bytes}, 80'd0);
    chk("rst_fsm", 80'(state_dbg), 80'd0);

    // Reset release with feed0 already waiting
    push_word(0, 1'b0, 8'hFF, 64'h0e00010102000000, 1'b1);
    push_word(0, 1'b1, 8'hFC, 64'h062020d206000000, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive_feeds();
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("init_ip_reset", 80'(ip_reset), 80'(k == 1));
      chk("init_feed_ready", 80'(feed_ready), 80'd0);
    end
    chk("init_idle_state", 80'(state_dbg), 80'd2);
    tick();
    chk("t2_first_ready", 80'(feed_ready), 80'b01);
    chk("t2_grant", 80'(grant_id), 80'd0);
    chk("t2_busy", 80'(busy), 80'd1);
    tick();
    chk("t2_word0", {15'd0, ip_data_valid, ip_byte_enables, ip_bytes},
        {15'd0, 1'b1, 8'hFF, 64'h0e00010102000000});
    tick();
    chk("t2_word1", {15'd0, ip_data_valid, ip_byte_enables, ip_bytes},
        {15'd0, 1'b1, 8'hFC, 64'h062020d206000000});
    chk("t2_gap_state", 80'(state_dbg), 80'd6);
    tick();
    chk("t2_gap_dv", 80'(ip_data_valid), 80'd0);
    chk("t2_gap_busy", 80'(busy), 80'd0);
    tick();
    chk("t2_idle_state", 80'(state_dbg), 80'd2);

    // Contention: expected order feed1, feed0, feed1
    push_word(1, 1'b0, 8'hFF, 64'h1111_0000_0000_0001, 1'b1);
    push_word(1, 1'b1, 8'hFF, 64'h1111_0000_0000_0002, 1'b1);
    push_word(0, 1'b0, 8'hFF, 64'h0000_AAAA_0000_0001, 1'b1);
    push_word(0, 1'b1, 8'hFF, 64'h0000_AAAA_0000_0002, 1'b1);
    push_word(1, 1'b0, 8'hFF, 64'h1111_0000_0000_0003, 1'b1);
    push_word(1, 1'b1, 8'hFF, 64'h1111_0000_0000_0004, 1'b1);
    drive_feeds();
    run_until_empty("t3_drained", 60);
    tick();
    tick();
    tick();
    chk("t3_grant_end", 80'(grant_id), 80'd1);
    chk("t3_busy_end", 80'(busy), 80'd0);

    // Backpressure mid-packet
    for (int i = 0; i < 4; i++)
      push_word(0, i == 3, 8'hFF, 64'hB0B0_0000_0000_0000 | 64'(i), 1'b1);
    drive_feeds();
    for (int i = 0; i < 20 && exp_q.size() > 2; i++) tick();
    chk("t4_mid_packet", 80'(exp_q.size()), 80'd2);
    ip_ready = 1'b0;
    #1;
    chk("t4_ready_low", 80'(feed_ready), 80'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_stall_dv", 80'(ip_data_valid), 80'd0);
      chk("t4_stall_ready", 80'(feed_ready), 80'd0);
      chk("t4_stall_grant", 80'(grant_id), 80'd0);
    end
    ip_ready = 1'b1;
    run_until_empty("t4_resumed", 30);
    tick();
    tick();
    tick();
    chk("t4_no_ovf", 80'(overflow_err), 80'd0);
    chk("t4_no_be_err", 80'(be_err), 80'd0);

    // Overflow: MW+5 words, only the first MW-1 reach the parser
    rst_cnt = 0;
    for (int i = 0; i < MW + 5; i++)
      push_word(0, i == MW + 4, 8'hFF, 64'hA500_0000_0000_0000 | 64'(i), i < MW - 1);
    drive_feeds();
    for (int i = 0; i < 10 && !busy; i++) tick();
    chk("t5_busy", 80'(busy), 80'd1);
    push_word(1, 1'b0, 8'hFF, 64'h1515_0000_0000_0001, 1'b1);
    push_word(1, 1'b1, 8'hFF, 64'h1515_0000_0000_0002, 1'b1);
    drive_feeds();
    run_until_empty("t5_drained", 300);
    tick();
    tick();
    chk("t5_ip_reset_pulses", 80'(rst_cnt), 80'd1);
    chk("t5_overflow_err", 80'(overflow_err), 80'd1);
    chk("t5_grant_feed1", 80'(grant_id), 80'd1);
    chk("t5_be_err_clear", 80'(be_err), 80'd0);

    // Byte-enable error on a non-last word, then a clean packet
    push_word(0, 1'b0, 8'hF0, 64'hC0C0_0000_0000_0001, 1'b1);
    push_word(0, 1'b1, 8'hFF, 64'hC0C0_0000_0000_0002, 1'b1);
    drive_feeds();
    run_until_empty("t6_be_packet", 20);
    tick();
    chk("t6_be_err_set", 80'(be_err), 80'd1);
    push_word(1, 1'b0, 8'hFF, 64'hD0D0_0000_0000_0001, 1'b1);
    push_word(1, 1'b1, 8'hFF, 64'hD0D0_0000_0000_0002, 1'b1);
    drive_feeds();
    run_until_empty("t6_clean_packet", 20);
    tick();
    chk("t6_be_err_sticky", 80'(be_err), 80'd1);

    // Asynchronous reset in the middle of a packet
    for (int i = 0; i < 5; i++)
      push_word(0, i == 4, 8'hFF, 64'hE0E0_0000_0000_0000 | 64'(i), 1'b1);
    drive_feeds();
    for (int i = 0; i < 20 && exp_q.size() > 3; i++) tick();
    chk("t6_mid_stream", {77'd0, state_dbg}, 80'd3);
    reset = 1'b1;
    #1;
    chk("t6_rst_outputs", {69'd0, ip_data_valid, ip_reset, feed_ready, grant_id, busy, overflow_err, be_err}, 80'd0);
    chk("t6_rst_bytes", {8'd0, ip_byte_enables, ip_bytes}, 80'd0);
    fq0.delete();
    fq1.delete();
    exp_q.delete();
    drive_feeds();
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("t6_reinit_pulse", 80'(ip_reset), 80'd1);
    chk("t6_reinit_state", 80'(state_dbg), 80'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
